bird_frame_sequencer: RTL and testbench

Per-frame scheduler that shares the single vga_adapter pixel-write port among NUM_BIRDS bird sprites. On each frame tick it snapshots all bird positions. It then walks an erase pass over every bird's previously drawn position, followed by a draw pass at the new positions, emitting one pixel per cycle. It sits between the frame counter, the bird position counters and vga_adapter (x/y/colour/plot).

---
 rtl/bird_frame_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_bird_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_frame_sequencer.sv
// Shares one vga_adapter pixel port among NUM_BIRDS sprites: erase pass at the old positions, then draw pass at the new ones.
// Optional macro WING_FLAP_EN: alternate frames suppress the up-wing or down-wing pixels during the draw pass.
module bird_frame_sequencer #(
    parameter int         NUM_BIRDS   = 4,
    parameter logic [2:0] BIRD_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [NUM_BIRDS-1:0]     bird_active,
    input  logic [8*NUM_BIRDS-1:0]   bird_x,
    input  logic [7*NUM_BIRDS-1:0]   bird_y,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               overrun_count,
    output logic [2:0]               fsm_state
);

    localparam int               BW        = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
    localparam logic [BW-1:0]    LAST_BIRD = BW'(NUM_BIRDS - 1);
    localparam logic [3:0]       LAST_PIX  = 4'd12;
    localparam logic [8:0]       X_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0]       Y_LIMIT   = 8'(SCREEN_H);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ERASE = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state, next_state;
    logic [BW-1:0]        bird_idx, next_bird;
    logic [3:0]           pix_idx, next_pix;

    logic [7:0]           old_x [NUM_BIRDS];
    logic [6:0]           old_y [NUM_BIRDS];
    logic [7:0]           new_x [NUM_BIRDS];
    logic [6:0]           new_y [NUM_BIRDS];
    logic [NUM_BIRDS-1:0] old_valid;
    logic [NUM_BIRDS-1:0] new_valid;

    logic                 erase_pass;
    logic                 pixel_pass;
    logic [7:0]           anchor_x;
    logic [6:0]           anchor_y;
    logic                 anchor_valid;
    logic [7:0]           pix_x;
    logic [6:0]           pix_y;
    logic                 on_screen;
    logic                 wing_ok;
    logic                 pix_plot;

    assign fsm_state = state;

    // Sprite shape: anchor at the beak, body trailing left, wings fanning up/down.
    function automatic logic [7:0] sprite_dx(input logic [3:0] j);
        case (j)
            4'd2:                sprite_dx = 8'hFF;
            4'd3:                sprite_dx = 8'hFE;
            4'd4, 4'd7, 4'd8:    sprite_dx = 8'hFD;
            4'd5, 4'd9, 4'd10:   sprite_dx = 8'hFC;
            4'd6, 4'd11, 4'd12:  sprite_dx = 8'hFB;
            default:             sprite_dx = 8'h00;
        endcase
    endfunction

    function automatic logic [6:0] sprite_dy(input logic [3:0] j);
        case (j)
            4'd1, 4'd7: sprite_dy = 7'd1;
            4'd8:       sprite_dy = 7'h7F;
            4'd9:       sprite_dy = 7'd2;
            4'd10:      sprite_dy = 7'h7E;
            4'd11:      sprite_dy = 7'd3;
            4'd12:      sprite_dy = 7'h7D;
            default:    sprite_dy = 7'd0;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        next_bird  = bird_idx;
        next_pix   = pix_idx;
        case (state)
            S_IDLE: begin
                if (frame_tick) next_state = S_LATCH;
            end
            S_LATCH: begin
                next_state = S_ERASE;
                next_bird  = '0;
                next_pix   = '0;
            end
            S_ERASE, S_DRAW: begin
                if (pix_idx == LAST_PIX) begin
                    next_pix = '0;
                    if (bird_idx == LAST_BIRD) begin
                        next_bird  = '0;
                        next_state = (state == S_ERASE) ? S_DRAW : S_DONE;
                    end else begin
                        next_bird = bird_idx + BW'(1);
                    end
                end else begin
                    next_pix = pix_idx + 4'd1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so the pixel is computed for the cycle being entered.
    always_comb begin
        erase_pass   = (next_state == S_ERASE);
        pixel_pass   = (next_state == S_ERASE) || (next_state == S_DRAW);
        anchor_x     = erase_pass ? old_x[next_bird] : new_x[next_bird];
        anchor_y     = erase_pass ? old_y[next_bird] : new_y[next_bird];
        anchor_valid = erase_pass ? old_valid[next_bird] : new_valid[next_bird];
        pix_x        = anchor_x + sprite_dx(next_pix);
        pix_y        = anchor_y + sprite_dy(next_pix);
        on_screen    = ({1'b0, pix_x} < X_LIMIT) && ({1'b0, pix_y} < Y_LIMIT);
        pix_plot     = anchor_valid && on_screen && wing_ok;
    end

`ifdef WING_FLAP_EN
    logic phase;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (state == S_DONE) begin
            phase <= ~phase;
        end
    end

    always_comb begin
        wing_ok = 1'b1;
        if (next_state == S_DRAW) begin
            if (!phase) begin
                wing_ok = !(next_pix == 4'd8 || next_pix == 4'd10 || next_pix == 4'd12);
            end else begin
                wing_ok = !(next_pix == 4'd7 || next_pix == 4'd9 || next_pix == 4'd11);
            end
        end
    end
`else
    assign wing_ok = 1'b1;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= S_IDLE;
            bird_idx      <= '0;
            pix_idx       <= '0;
            old_valid     <= '0;
            new_valid     <= '0;
            vga_x         <= 8'd0;
            vga_y         <= 7'd0;
            vga_colour    <= 3'd0;
            vga_plot      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun_count <= 8'd0;
        end else begin
            state      <= next_state;
            bird_idx   <= next_bird;
            pix_idx    <= next_pix;
            busy       <= (next_state != S_IDLE);
            frame_done <= (next_state == S_DONE);
            if (pixel_pass) begin
                vga_x      <= pix_x;
                vga_y      <= pix_y;
                vga_colour <= erase_pass ? BG_COLOUR : BIRD_COLOUR;
                vga_plot   <= pix_plot;
            end else begin
                vga_plot <= 1'b0;
            end
            if (frame_tick && (state != S_IDLE) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
            if (state == S_LATCH) begin
                new_valid <= bird_active;
            end
            if (state == S_DONE) begin
                old_valid <= new_valid;
            end
        end
    end

    // Position registers carry no reset: old_valid alone decides whether they are ever plotted.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BIRDS; i++) begin
                if (state == S_LATCH) begin
                    new_x[i] <= bird_x[8*i +: 8];
                    new_y[i] <= bird_y[7*i +: 7];
                end
                if (state == S_DONE) begin
                    old_x[i] <= new_x[i];
                    old_y[i] <= new_y[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_bird_frame_sequencer.sv
// Bench for bird_frame_sequencer: a table of frames with hand-derived plot counts, overrun and
// mid-frame reset sequences, then random frames, all checked cycle by cycle against a frame model.
`timescale 1ns/1ps
module tb_bird_frame_sequencer;

    localparam int NB       = 4;
    localparam int P        = 13;
    localparam int PASS_LEN = NB * P;
    localparam int DONE_CYC = 2 + 2 * PASS_LEN;

`ifdef WING_FLAP_EN
    localparam bit FLAP = 1'b1;
`else
    localparam bit FLAP = 1'b0;
`endif

    typedef logic [8*NB-1:0] xs_t;
    typedef logic [7*NB-1:0] ys_t;
    typedef logic [NB-1:0]   act_t;

    logic        CLOCK_50    = 1'b0;
    logic        reset       = 1'b1;
    logic        frame_tick  = 1'b0;
    act_t        bird_active = '0;
    xs_t         bird_x      = '0;
    ys_t         bird_y      = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_count;
    logic [2:0]  fsm_state;

    bird_frame_sequencer dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .bird_active   (bird_active),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_count (overrun_count),
        .fsm_state     (fsm_state)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    int dx_tab[P] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
    int dy_tab[P] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

    // Model of what is on screen and what the sequencer remembers between frames.
    int         m_old_x[NB];
    int         m_old_y[NB];
    bit         m_old_valid[NB];
    bit         m_old_known[NB];
    bit         m_phase;
    int         m_ovr;
    int         m_last_x, m_last_y, m_last_c;
    logic [2:0] idle_code;

    bit ovr_at[1:DONE_CYC];
    int erase_plots, draw_plots;

    typedef struct {
        xs_t  bx;
        ys_t  by;
        act_t act;
        int   ovr_a;
        int   ovr_b;
        int   exp_erase;
        int   exp_draw;
        int   exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit wing_cut(input bit phase, input int j);
        if (!FLAP) return 1'b0;
        if (!phase) return (j == 8 || j == 10 || j == 12);
        return (j == 7 || j == 9 || j == 11);
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("reset_outputs",
              {busy, frame_done, vga_plot, overrun_count, vga_x, vga_y, vga_colour}, 64'd0);
        idle_code = fsm_state;
        reset     = 1'b0;
        m_ovr     = 0;
        m_phase   = 1'b0;
        m_last_x  = 0;
        m_last_y  = 0;
        m_last_c  = 0;
        for (int i = 0; i < NB; i++) begin
            m_old_valid[i] = 1'b0;
            m_old_known[i] = 1'b0;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of the first idle cycle after the frame.
    task automatic run_frame(input xs_t bx, input ys_t by, input act_t act, input int abort_at);
        int fx[NB];
        int fy[NB];
        bit fv[NB];
        for (int i = 0; i < NB; i++) begin
            fx[i] = int'(bx[8*i +: 8]);
            fy[i] = int'(by[7*i +: 7]);
            fv[i] = act[i];
        end
        bird_active = act;
        bird_x      = bx;
        bird_y      = by;
        frame_tick  = 1'b1;
        @(negedge CLOCK_50);
        frame_tick  = 1'b0;
        erase_plots = 0;
        draw_plots  = 0;
        for (int n = 1; n <= DONE_CYC; n++) begin
            bit e_plot, xy_known, erase;
            int e_x, e_y, e_c, s, b, j;
            e_plot   = 1'b0;
            xy_known = 1'b1;
            e_x      = m_last_x;
            e_y      = m_last_y;
            e_c      = m_last_c;
            if (n >= 2 && n < DONE_CYC) begin
                s     = n - 2;
                erase = (s < PASS_LEN);
                if (!erase) s = s - PASS_LEN;
                b = s / P;
                j = s % P;
                if (erase) begin
                    e_x      = (m_old_x[b] + dx_tab[j]) & 255;
                    e_y      = (m_old_y[b] + dy_tab[j]) & 127;
                    e_c      = 0;
                    e_plot   = m_old_valid[b] && e_x < 160 && e_y < 120;
                    xy_known = m_old_known[b];
                    if (vga_plot) erase_plots++;
                end else begin
                    e_x    = (fx[b] + dx_tab[j]) & 255;
                    e_y    = (fy[b] + dy_tab[j]) & 127;
                    e_c    = 7;
                    e_plot = fv[b] && e_x < 160 && e_y < 120 && !wing_cut(m_phase, j);
                    if (vga_plot) draw_plots++;
                end
                m_last_x = e_x;
                m_last_y = e_y;
                m_last_c = e_c;
            end
            check($sformatf("ctl cyc=%0d busy/done/plot/ovr", n),
                  {busy, frame_done, vga_plot, overrun_count},
                  {1'b1, (n == DONE_CYC), e_plot, 8'(m_ovr)});
            check($sformatf("busy_state cyc=%0d", n), 64'(fsm_state != idle_code), 64'd1);
            if (xy_known) begin
                check($sformatf("pixel cyc=%0d x/y/colour", n),
                      {vga_x, vga_y, vga_colour}, {8'(e_x), 7'(e_y), 3'(e_c)});
            end
            if (n == abort_at) begin
                frame_tick = 1'b0;
                return;
            end
            if (n == 2) begin
                bird_active = act_t'($urandom);
                bird_x      = xs_t'($urandom);
                bird_y      = ys_t'($urandom);
            end
            frame_tick = ovr_at[n];
            if (ovr_at[n]) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            @(negedge CLOCK_50);
        end
        frame_tick = 1'b0;
        check("idle_after_frame busy/done/plot/ovr",
              {busy, frame_done, vga_plot, overrun_count}, {3'b000, 8'(m_ovr)});
        check("idle_after_frame hold x/y/colour",
              {vga_x, vga_y, vga_colour}, {8'(m_last_x), 7'(m_last_y), 3'(m_last_c)});
        check("idle_after_frame state", {61'd0, fsm_state}, {61'd0, idle_code});
        for (int i = 0; i < NB; i++) begin
            m_old_x[i]     = fx[i];
            m_old_y[i]     = fy[i];
            m_old_valid[i] = fv[i];
            m_old_known[i] = 1'b1;
        end
        m_phase = !m_phase;
    endtask

    task automatic clear_ovr();
        foreach (ovr_at[i]) ovr_at[i] = 1'b0;
    endtask

    initial begin
        // Draw counts in the flap build drop the suppressed wing pixels that would otherwise be on screen.
        vecs[0] = '{{8'd30, 8'd20, 8'd10, 8'd50},  {7'd30, 7'd20, 7'd10, 7'd40},  4'b0001, 0, 0,   0, FLAP ? 10 : 13, 0};
        vecs[1] = '{{8'd30, 8'd20, 8'd10, 8'd51},  {7'd30, 7'd20, 7'd10, 7'd40},  4'b0001, 0, 0,  13, FLAP ? 10 : 13, 0};
        vecs[2] = '{{8'd30, 8'd20, 8'd10, 8'd2},   {7'd30, 7'd20, 7'd10, 7'd118}, 4'b0001, 0, 0,  13, 4, 0};
        vecs[3] = '{{8'd30, 8'd20, 8'd10, 8'd60},  {7'd30, 7'd20, 7'd10, 7'd60},  4'b0001, 20, 106, 4, FLAP ? 10 : 13, 2};
        vecs[4] = '{{8'd80, 8'd159, 8'd0, 8'd100}, {7'd100, 7'd119, 7'd0, 7'd50}, 4'b1111, 0, 0,  13, FLAP ? 28 : 37, 2};
        vecs[5] = '{{8'd1, 8'd2, 8'd3, 8'd4},      {7'd1, 7'd2, 7'd3, 7'd4},      4'b0000, 0, 0,  37, 0, 2};
        vecs[6] = '{{8'd10, 8'd5, 8'd3, 8'd200},   {7'd1, 7'd5, 7'd2, 7'd100},    4'b1010, 0, 0,   0, FLAP ? 16 : 18, 2};

        clear_ovr();
        do_reset();

        for (int v = 0; v < 7; v++) begin
            clear_ovr();
            if (vecs[v].ovr_a > 0) ovr_at[vecs[v].ovr_a] = 1'b1;
            if (vecs[v].ovr_b > 0) ovr_at[vecs[v].ovr_b] = 1'b1;
            run_frame(vecs[v].bx, vecs[v].by, vecs[v].act, 0);
            check($sformatf("vec%0d erase_plots", v), 64'(erase_plots), 64'(vecs[v].exp_erase));
            check($sformatf("vec%0d draw_plots", v), 64'(draw_plots), 64'(vecs[v].exp_draw));
            check($sformatf("vec%0d overrun_count", v), 64'(overrun_count), 64'(vecs[v].exp_ovr));
        end

        // Overrun saturation: a tick held through every busy cycle of three frames.
        foreach (ovr_at[i]) ovr_at[i] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame({8'd90, 8'd70, 8'd50, 8'd30}, {7'd90, 7'd70, 7'd50, 7'd30}, 4'b0101, 0);
        end
        check("overrun_saturated", 64'(overrun_count), 64'd255);
        clear_ovr();

        // Reset sampled at k+70 abandons the frame; the following frame erases nothing.
        run_frame({8'd10, 8'd10, 8'd10, 8'd70}, {7'd10, 7'd10, 7'd10, 7'd30}, 4'b0001, 69);
        do_reset();
        run_frame({8'd10, 8'd10, 8'd10, 8'd70}, {7'd10, 7'd10, 7'd10, 7'd30}, 4'b0001, 0);
        check("post_reset erase_plots", 64'(erase_plots), 64'd0);
        check("post_reset draw_plots", 64'(draw_plots), FLAP ? 64'd10 : 64'd13);

        for (int r = 0; r < 20; r++) begin
            foreach (ovr_at[i]) ovr_at[i] = ($urandom_range(15) == 0);
            run_frame(xs_t'($urandom), ys_t'($urandom), act_t'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
